tri_raster_scan: RTL and testbench

- Sequential, parametrised successor to the combinational per-pixel triangle test.
- Accepts one triangle (three vertices plus flat RGB colour) through a valid/ready handshake.
- Walks the triangle's screen-clamped bounding box in row-major order at one candidate pixel per cycle, and emits covered pixels as an (x, y, r, g, b) stream with valid/ready backpressure.
- Sits between triangle setup and the framebuffer writer.

---
 rtl/tri_raster_scan.sv | 210 +++++++++++++++++++++
 tb/tb_tri_raster_scan.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_raster_scan.sv
// tri_raster_scan: walks a triangle's screen-clamped bounding box at one candidate per cycle and
// streams covered pixels. Define TRI_RASTER_BOTH_WINDINGS_EN to also fill negative-area triangles.
module tri_raster_scan #(
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v2y,
    input  logic [COORD_W-1:0] v3x,
    input  logic [COORD_W-1:0] v3y,
    input  logic [COLOR_W-1:0] tri_r,
    input  logic [COLOR_W-1:0] tri_g,
    input  logic [COLOR_W-1:0] tri_b,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic               busy,
    output logic               done
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int EW = 2 * COORD_W + 3;
    localparam logic [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

    state_t state;

    // Full-precision edge function; widths are chosen so nothing can wrap.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [COORD_W-1:0] ax, ay, bx, by, px, py
    );
        logic signed [DW-1:0] dbx, dby, dpx, dpy;
        logic signed [PW-1:0] m0, m1;
        dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dby = $signed({1'b0, by}) - $signed({1'b0, ay});
        dpx = $signed({1'b0, px}) - $signed({1'b0, ax});
        dpy = $signed({1'b0, py}) - $signed({1'b0, ay});
        m0  = PW'(dbx) * PW'(dpy);
        m1  = PW'(dby) * PW'(dpx);
        return EW'(m0) - EW'(m1);
    endfunction

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] sat_lim(input logic [COORD_W-1:0] v, lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [COORD_W-1:0] vx1, vy1, vx2, vy2, vx3, vy3;
    logic [COLOR_W-1:0] col_r, col_g, col_b;
    logic [COORD_W-1:0] bb_minx, bb_miny, bb_maxx, bb_maxy;
    logic [COORD_W-1:0] cur_x_p0, cur_y_p0;

    logic [COORD_W-1:0] s_minx, s_miny, s_maxx, s_maxy;
    logic signed [EW-1:0] area_s;
    logic                 setup_empty;

    assign s_minx      = min3(vx1, vx2, vx3);
    assign s_miny      = min3(vy1, vy2, vy3);
    assign s_maxx      = sat_lim(max3(vx1, vx2, vx3), XLIM);
    assign s_maxy      = sat_lim(max3(vy1, vy2, vy3), YLIM);
    assign area_s      = edge_fn(vx1, vy1, vx2, vy2, vx3, vy3);
    assign setup_empty = (area_s == '0) || (s_minx > XLIM) || (s_miny > YLIM);

    logic signed [EW-1:0] w0_p0, w1_p0, w2_p0;
    logic                 covered_p0;
    logic                 out_free;
    logic                 vld_p0;
    logic                 last_col, last_row;

    assign w0_p0 = edge_fn(vx2, vy2, vx3, vy3, cur_x_p0, cur_y_p0);
    assign w1_p0 = edge_fn(vx3, vy3, vx1, vy1, cur_x_p0, cur_y_p0);
    assign w2_p0 = edge_fn(vx1, vy1, vx2, vy2, cur_x_p0, cur_y_p0);

`ifdef TRI_RASTER_BOTH_WINDINGS_EN
    logic                 flip;
    logic signed [EW-1:0] f0_p0, f1_p0, f2_p0;
    assign f0_p0      = flip ? -w0_p0 : w0_p0;
    assign f1_p0      = flip ? -w1_p0 : w1_p0;
    assign f2_p0      = flip ? -w2_p0 : w2_p0;
    assign covered_p0 = !f0_p0[EW-1] && !f1_p0[EW-1] && !f2_p0[EW-1];
`else
    assign covered_p0 = !w0_p0[EW-1] && !w1_p0[EW-1] && !w2_p0[EW-1];
`endif

    assign out_free = !pix_valid || pix_ready;
    assign vld_p0   = (state == SCAN) && out_free;
    assign last_col = (cur_x_p0 == bb_maxx);
    assign last_row = (cur_y_p0 == bb_maxy);

    // Triangle latch, bounding box and scan cursor (stage p0).
    always_ff @(posedge clk) begin
        if (state == IDLE && tri_valid && tri_ready) begin
            vx1   <= v1x;
            vy1   <= v1y;
            vx2   <= v2x;
            vy2   <= v2y;
            vx3   <= v3x;
            vy3   <= v3y;
            col_r <= tri_r;
            col_g <= tri_g;
            col_b <= tri_b;
        end
        if (state == SETUP) begin
            bb_minx  <= s_minx;
            bb_miny  <= s_miny;
            bb_maxx  <= s_maxx;
            bb_maxy  <= s_maxy;
            cur_x_p0 <= s_minx;
            cur_y_p0 <= s_miny;
`ifdef TRI_RASTER_BOTH_WINDINGS_EN
            flip     <= area_s[EW-1];
`endif
        end
        if (vld_p0 && !(last_col && last_row)) begin
            if (last_col) begin
                cur_x_p0 <= bb_minx;
                cur_y_p0 <= cur_y_p0 + COORD_W'(1);
            end else begin
                cur_x_p0 <= cur_x_p0 + COORD_W'(1);
            end
        end
    end

    // Control FSM and output register (stage p1).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
        end else begin
            // done is registered from the DONE state, so the pulse lands one cycle later.
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (tri_valid && tri_ready) begin
                        state     <= SETUP;
                        tri_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= setup_empty ? DONE : SCAN;
                end
                SCAN: begin
                    if (vld_p0) begin
                        pix_valid <= covered_p0;
                        if (covered_p0) begin
                            pix_x <= cur_x_p0;
                            pix_y <= cur_y_p0;
                            pix_r <= col_r;
                            pix_g <= col_g;
                            pix_b <= col_b;
                        end
                        if (last_col && last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        pix_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    tri_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed self-checking bench for tri_raster_scan: coverage, winding, clamping, degenerate,
// backpressure and mid-scan reset, each in its own task.
module tb_tri_raster_scan;

    localparam int CW = 10;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [CW-1:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
    logic [KW-1:0] tri_r = '0, tri_g = '0, tri_b = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [CW-1:0] pix_x, pix_y;
    logic [KW-1:0] pix_r, pix_g, pix_b;
    logic          busy;
    logic          done;

    tri_raster_scan #(.COORD_W(CW), .COLOR_W(KW), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .reset_n(reset_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
        .tri_r(tri_r), .tri_g(tri_g), .tri_b(tri_b),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int qx[$];
    int qy[$];
    bit col_bad;
    int stall_hits;

    // Row-major list of pixels with x+y<=4 over the 5x5 box; returns first divergent index or -1.
    function automatic int basic_mismatch();
        int i = 0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (x + y <= 4) begin
                    if (i >= qx.size()) return i;
                    if (qx[i] != x || qy[i] != y) return i;
                    i++;
                end
            end
        end
        if (i != qx.size()) return i;
        return -1;
    endfunction

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int r, input int g, input int b,
                           input int stall_at, input int stall_x, input int stall_y,
                           input int rst_at,
                           output int done_cyc, output int done_cnt, output int first_vld);
        int  k;
        int  stall_left;
        int  wait_n;
        bit  finished;
        bit  did_rst;
        qx.delete();
        qy.delete();
        col_bad    = 1'b0;
        stall_hits = 0;
        done_cyc   = -1;
        done_cnt   = 0;
        first_vld  = -1;
        stall_left = 5;
        finished   = 1'b0;
        did_rst    = 1'b0;
        v1x = CW'(ax); v1y = CW'(ay);
        v2x = CW'(bx); v2y = CW'(by);
        v3x = CW'(cx); v3y = CW'(cy);
        tri_r = KW'(r); tri_g = KW'(g); tri_b = KW'(b);
        tri_valid = 1'b1;
        wait_n = 0;
        while (tri_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        checks++;
        if (tri_ready !== 1'b1) begin
            errors++;
            $display("FAIL tri_ready_wait: got %b need 1", tri_ready);
        end
        @(posedge clk); #1;
        tri_valid = 1'b0;
        k = 1;
        while (!finished) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (pix_valid === 1'b1 && first_vld < 0) first_vld = k;
            if (stall_at >= 0 && pix_valid === 1'b1 && qx.size() == stall_at && stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
                stall_hits++;
                checks++;
                if (pix_x !== CW'(stall_x) || pix_y !== CW'(stall_y) || pix_r !== KW'(r)) begin
                    errors++;
                    $display("FAIL stall_hold: got (%0d,%0d) r=%0d need (%0d,%0d) r=%0d",
                             pix_x, pix_y, pix_r, stall_x, stall_y, r);
                end
            end else begin
                pix_ready = 1'b1;
            end
            if (pix_valid === 1'b1 && pix_ready) begin
                qx.push_back(int'(pix_x));
                qy.push_back(int'(pix_y));
                if (pix_r !== KW'(r) || pix_g !== KW'(g) || pix_b !== KW'(b)) col_bad = 1'b1;
            end
            if (rst_at >= 0 && !did_rst && qx.size() == rst_at) begin
                did_rst = 1'b1;
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                checks++;
                if (pix_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_pix_valid: got %b need 0", pix_valid);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_busy: got %b need 0", busy);
                end
                checks++;
                if (tri_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_tri_ready: got %b need 1", tri_ready);
                end
                finished = 1'b1;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) finished = 1'b1;
            if (!finished && k >= 3000) begin
                checks++;
                errors++;
                $display("FAIL cycle_budget: ran %0d cycles without done, need done", k);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tri_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b need 1 0 0", tri_ready, busy, done);
        end
        checks++;
        if (pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pix_valid: got %b need 0", pix_valid);
        end
        checks++;
        if ({pix_x, pix_y, pix_r, pix_g, pix_b} !== '0) begin
            errors++;
            $display("FAIL reset_pix_data: got x=%0d y=%0d rgb=%0d,%0d,%0d need all 0",
                     pix_x, pix_y, pix_r, pix_g, pix_b);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc, dn, fv, mm;
        run_tri(0, 0, 4, 0, 0, 4, 255, 0, 0, -1, 0, 0, -1, dc, dn, fv);
        checks++;
        if (qx.size() != 15) begin
            errors++;
            $display("FAIL basic_count: got %0d need 15", qx.size());
        end
        mm = basic_mismatch();
        checks++;
        if (mm != -1) begin
            errors++;
            $display("FAIL basic_order: diverges at index %0d, need full match", mm);
        end
        checks++;
        if (qx.size() == 0 || qx[0] != 0 || qy[0] != 0 || qx[qx.size()-1] != 0 || qy[qy.size()-1] != 4) begin
            errors++;
            $display("FAIL basic_ends: got %0d pixels, need first (0,0) last (0,4)", qx.size());
        end
        checks++;
        if (col_bad) begin
            errors++;
            $display("FAIL basic_colour: got a pixel not (255,0,0), need all (255,0,0)");
        end
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d need 1", dn);
        end
        checks++;
        if (fv != 3) begin
            errors++;
            $display("FAIL basic_latency: first pix_valid cycle %0d need 3", fv);
        end
        checks++;
        if (tri_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got ready=%b busy=%b need 1 0", tri_ready, busy);
        end
    endtask

    task automatic test_winding();
        int dc, dn, fv;
        run_tri(0, 0, 0, 4, 4, 0, 0, 255, 0, -1, 0, 0, -1, dc, dn, fv);
        checks++;
        if (dn != 1) begin
            errors++;
            $display("FAIL winding_done: got %0d pulses need 1", dn);
        end
`ifdef TRI_RASTER_BOTH_WINDINGS_EN
        checks++;
        if (basic_mismatch() != -1) begin
            errors++;
            $display("FAIL winding_pixels: got %0d pixels, need the 15-pixel basic set", qx.size());
        end
`else
        checks++;
        if (qx.size() != 0) begin
            errors++;
            $display("FAIL winding_pixels: got %0d pixels need 0", qx.size());
        end
`endif
    endtask

    task automatic test_clamp();
        int  dc, dn, fv;
        bit  out_of_box = 1'b0;
        run_tri(630, 470, 700, 470, 630, 540, 1, 2, 3, -1, 0, 0, -1, dc, dn, fv);
        foreach (qx[i]) begin
            if (qx[i] < 630 || qx[i] > 639 || qy[i] < 470 || qy[i] > 479) out_of_box = 1'b1;
        end
        checks++;
        if (qx.size() != 100) begin
            errors++;
            $display("FAIL clamp_count: got %0d need 100", qx.size());
        end
        checks++;
        if (out_of_box) begin
            errors++;
            $display("FAIL clamp_range: got a pixel outside x 630..639 y 470..479");
        end
        checks++;
        if (qx.size() == 0 || qx[0] != 630 || qy[0] != 470 || qx[qx.size()-1] != 639 || qy[qy.size()-1] != 479) begin
            errors++;
            $display("FAIL clamp_ends: got %0d pixels, need first (630,470) last (639,479)", qx.size());
        end
        checks++;
        if (col_bad || dn != 1) begin
            errors++;
            $display("FAIL clamp_colour_done: colour_bad=%0d done=%0d need 0 and 1", col_bad, dn);
        end
    endtask

    task automatic test_degenerate();
        int dc, dn, fv;
        run_tri(0, 0, 2, 2, 4, 4, 9, 9, 9, -1, 0, 0, -1, dc, dn, fv);
        checks++;
        if (qx.size() != 0) begin
            errors++;
            $display("FAIL degen_count: got %0d need 0", qx.size());
        end
        checks++;
        if (dc != 3 || dn != 1) begin
            errors++;
            $display("FAIL degen_done: got cycle %0d count %0d need cycle 3 count 1", dc, dn);
        end
    endtask

    task automatic test_backpressure();
        int dc, dn, fv;
        run_tri(0, 0, 4, 0, 0, 4, 255, 0, 0, 2, 2, 0, -1, dc, dn, fv);
        checks++;
        if (stall_hits != 5) begin
            errors++;
            $display("FAIL bp_stall_cycles: got %0d need 5", stall_hits);
        end
        checks++;
        if (basic_mismatch() != -1) begin
            errors++;
            $display("FAIL bp_sequence: got %0d pixels, need the 15-pixel basic sequence", qx.size());
        end
        checks++;
        if (dn != 1 || col_bad) begin
            errors++;
            $display("FAIL bp_done_colour: done=%0d colour_bad=%0d need 1 and 0", dn, col_bad);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dc, dn, fv;
        run_tri(0, 0, 4, 0, 0, 4, 255, 0, 0, -1, 0, 0, 4, dc, dn, fv);
        checks++;
        if (qx.size() != 4 || dn != 0) begin
            errors++;
            $display("FAIL rst_prefix: got %0d pixels done=%0d need 4 and 0", qx.size(), dn);
        end
        run_tri(0, 0, 4, 0, 0, 4, 0, 0, 200, -1, 0, 0, -1, dc, dn, fv);
        checks++;
        if (basic_mismatch() != -1 || col_bad || dn != 1) begin
            errors++;
            $display("FAIL rst_followup: got %0d pixels colour_bad=%0d done=%0d need 15 0 1",
                     qx.size(), col_bad, dn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_winding();
        test_clamp();
        test_degenerate();
        test_backpressure();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
